fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_pkg.sv | 9 +
 rtl/skid_buf2.sv | 49 ++++
 rtl/fifo_rd_stream.sv | 58 +++++
 tb/tb_fifo_rd_stream.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the fifo read-side streaming adapter.
package fifo_pkg;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned BUF_DEPTH_DEF  = 2;
    localparam int unsigned COUNT_WIDTH    = 32;

    typedef logic [1:0]             occ_t;
    typedef logic [COUNT_WIDTH-1:0] count_t;
endpackage

// File: rtl/skid_buf2.sv
// Two-entry ring buffer: push at tail, pop at head, registered head data and occupancy.
module skid_buf2 import fifo_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output occ_t                  occ
);
    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // A push into a full buffer is only legal when the head retires in the same cycle.
    always_comb begin
        do_pop  = pop && (occ != 2'd0);
        do_push = push && ((occ != 2'd2) || do_pop);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ_t'(occ + 2'd1);
                2'b01:   occ <= occ_t'(occ - 2'd1);
                default: occ <= occ;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
endmodule

// File: rtl/fifo_rd_stream.sv
// Converts a pop/next-cycle-data fifo read port into a valid/ready stream with
// credit-based pop issue so the 2-entry output buffer can never overflow.
module fifo_rd_stream import fifo_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned BUF_DEPTH  = BUF_DEPTH_DEF
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output count_t                words_out
);
    if (BUF_DEPTH != 2) begin : g_depth_check
        $error("fifo_rd_stream: BUF_DEPTH must be 2");
    end

    occ_t       occ;
    logic       inflight;
    logic       handshake;
    logic [2:0] credit_used;

    // Pop only if the word still fits once this cycle's capture and retire settle.
    always_comb begin
        handshake   = m_valid && m_ready;
        credit_used = 3'({1'b0, occ}) + 3'(inflight) - 3'(handshake);
        fifo_rd_en  = resetn && !fifo_empty && (credit_used < 3'd2);
    end

    assign m_valid = (occ != 2'd0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            inflight  <= 1'b0;
            words_out <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (handshake) begin
                words_out <= count_t'(words_out + 32'd1);
            end
        end
    end

    skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clock     (clock),
        .resetn    (resetn),
        .push      (inflight),
        .push_data (fifo_data_out),
        .pop       (handshake),
        .head_data (m_data),
        .occ       (occ)
    );
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: a queue-based 256-deep upstream fifo feeds the DUT; a negedge
// monitor checks stream order, hold stability, the handshake counter and pop legality.
module tb_fifo_rd_stream;
    localparam int unsigned DW    = 32;
    localparam int          DEPTH = 256;

    logic          clock = 1'b0;
    logic          resetn;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [31:0]   words_out;

    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    int            fcnt;
    int            accepted;
    int            pops;
    int            hs_cnt;
    int            checks = 0;
    int            errors = 0;

    always #5 clock = ~clock;

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (2)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_rd_en    (fifo_rd_en),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .words_out     (words_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Upstream fifo model; every accepted word is also the next expected stream word.
    assign fifo_empty = (fcnt == 0);
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fq.delete();
            exp_q.delete();
            fcnt          <= 0;
            fifo_data_out <= '0;
            accepted = 0;
            pops     = 0;
        end else begin
            if (fifo_rd_en && fcnt != 0) begin
                fifo_data_out <= fq.pop_front();
                pops++;
            end
            if (wr_en && fq.size() < DEPTH) begin
                fq.push_back(wr_data);
                exp_q.push_back(wr_data);
                accepted++;
            end
            fcnt <= fq.size();
        end
    end

    // Monitor: a handshake seen at a negedge happens at the following posedge.
    logic          pv;
    logic          pr;
    logic [DW-1:0] pd;
    always @(negedge clock) begin
        logic [DW-1:0] e;
        if (!resetn) begin
            hs_cnt = 0;
            pv     = 1'b0;
            pr     = 1'b0;
            pd     = '0;
        end else begin
            if (fifo_empty) chk("rd_en_while_empty", 64'(fifo_rd_en), 64'd0);
            if (pv && !pr) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_data", 64'(m_data), 64'(pd));
            end
            chk("words_out", 64'(words_out), 64'(32'(hs_cnt)));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_data", 64'(m_data), 64'(e));
                end
                hs_cnt++;
            end
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait for every accepted word to leave the stream; mode 0 ready=1, 1 toggle, 2 random.
    task automatic drain(input int mode, input int budget);
        int c;
        for (c = 0; c < budget; c++) begin
            if (exp_q.size() == 0) break;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
        end
        if (c == budget) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        m_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_words_out", 64'(words_out), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] w[4];
        int            p0;
        resetn  = 1'b0;
        m_ready = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        tick();
        do_reset();
        tick();

        // 24 random words with random write gaps, ready held high
        m_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            wr_en   = 1'b1;
            wr_data = $urandom;
            tick();
            wr_en = 1'b0;
            if ($urandom_range(0, 1) == 1) tick();
        end
        drain(0, 200);
        chk("t24_words_out", 64'(words_out), 64'd24);
        for (int i = 0; i < 4; i++) begin
            chk("t24_rd_en_idle", 64'(fifo_rd_en), 64'd0);
            tick();
        end

        // single word into an empty fifo: valid two cycles after empty falls
        wr_en   = 1'b1;
        wr_data = $urandom;
        tick();
        wr_en = 1'b0;
        chk("lat_cycle0", 64'(m_valid), 64'd0);
        tick();
        chk("lat_cycle1", 64'(m_valid), 64'd0);
        tick();
        chk("lat_cycle2", 64'(m_valid), 64'd1);
        drain(0, 50);

        // four words with ready low: exactly two pops, then four consecutive handshakes
        m_ready = 1'b0;
        p0      = pops;
        for (int i = 0; i < 4; i++) begin
            w[i]    = $urandom;
            wr_en   = 1'b1;
            wr_data = w[i];
            tick();
        end
        wr_en = 1'b0;
        repeat (8) tick();
        chk("stall_pops", 64'(pops - p0), 64'd2);
        chk("stall_rd_en_full", 64'(fifo_rd_en), 64'd0);
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_head", 64'(m_data), 64'(w[0]));
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("burst_valid", 64'(m_valid), 64'd1);
            chk("burst_data", 64'(m_data), 64'(w[i]));
            tick();
        end
        drain(0, 50);

        // 100 back-to-back words, ready toggling every cycle
        for (int i = 0; i < 100; i++) begin
            wr_en   = 1'b1;
            wr_data = $urandom;
            m_ready = (i % 2 == 0);
            tick();
        end
        wr_en = 1'b0;
        drain(1, 400);
        chk("toggle_words_out", 64'(words_out), 64'(32'(accepted)));

        // random writes against random backpressure
        for (int i = 0; i < 150; i++) begin
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_data = $urandom;
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        wr_en = 1'b0;
        drain(2, 1000);
        chk("rand_words_out", 64'(words_out), 64'(32'(accepted)));

        // reset mid-stream discards buffered and in-flight words
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = $urandom;
            tick();
        end
        chk("pre_reset_valid", 64'(m_valid), 64'd1);
        do_reset();
        wr_en = 1'b0;
        tick();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = $urandom;
            tick();
        end
        wr_en = 1'b0;
        drain(0, 100);
        chk("post_reset_words_out", 64'(words_out), 64'd5);

        // overfill a 256-deep fifo with 261 writes while ready is low
        do_reset();
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 261; i++) begin
            wr_en   = 1'b1;
            wr_data = $urandom;
            tick();
        end
        wr_en = 1'b0;
        tick();
        chk("full_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("full_valid", 64'(m_valid), 64'd1);
        drain(0, 1000);
        chk("full_words_out", 64'(words_out), 64'(32'(accepted)));
        chk("full_pops", 64'(pops), 64'(accepted));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
